sd_block_loader: RTL and testbench

//  Bulk-load sequencer downstream of the SD controller. It requests N consecutive 512-byte SD blocks
//  (via sd_addr/sd_re), latches each 4096-bit rdata, and streams it as 32-bit words with valid/ready

---
 rtl/sd_block_loader_pkg.sv | 28 ++
 rtl/sd_block_loader_if.sv | 37 +++
 rtl/sd_block_shift_buf.sv | 31 +++
 rtl/sd_block_loader.sv | 190 +++++++++++++++++++
 tb/tb_sd_block_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_block_loader_pkg.sv
`default_nettype none
// ==================================================================
// sd_loader_pkg : shared constants for the SD bulk-load sequencer
// Rev 1.0
// ==================================================================
package sd_loader_pkg;

   localparam int DEF_BLOCK_BITS = 4096;
   localparam int DEF_WORD_W     = 32;
   localparam int WORDS          = DEF_BLOCK_BITS / DEF_WORD_W;

   localparam int STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_IDLE      = 3'd0;
   localparam state_t S_WAIT_INIT = 3'd1;
   localparam state_t S_REQ       = 3'd2;
   localparam state_t S_REL       = 3'd3;
   localparam state_t S_STREAM    = 3'd4;
   localparam state_t S_DONE      = 3'd5;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_INIT_TO = 2'b01;
   localparam logic [1:0] ERR_READ    = 2'b10;
   localparam logic [1:0] ERR_READ_TO = 2'b11;

endpackage
`default_nettype wire

// File: rtl/sd_block_loader_if.sv
`default_nettype none
// ==================================================================
// sd_block_loader_if : SD controller link plus outbound word stream
// Rev 1.0
// ==================================================================
interface sd_block_loader_if
   import sd_loader_pkg::*;
#(
   parameter int BLOCK_BITS = DEF_BLOCK_BITS,
   parameter int WORD_W     = DEF_WORD_W
) ();

   logic [31:0]           sd_addr;
   logic                  sd_re;
   logic [BLOCK_BITS-1:0] sd_rdata;
   logic                  sd_read_ok;
   logic                  sd_read_err;
   logic                  sd_init_ok;

   logic                  m_valid;
   logic [WORD_W-1:0]     m_data;
   logic [31:0]           m_addr;
   logic                  m_last;
   logic                  m_ready;

   modport master (
      output sd_addr, sd_re, m_valid, m_data, m_addr, m_last,
      input  sd_rdata, sd_read_ok, sd_read_err, sd_init_ok, m_ready
   );

   modport slave (
      input  sd_addr, sd_re, m_valid, m_data, m_addr, m_last,
      output sd_rdata, sd_read_ok, sd_read_err, sd_init_ok, m_ready
   );

endinterface
`default_nettype wire

// File: rtl/sd_block_shift_buf.sv
`default_nettype none
// ==================================================================
// sd_block_shift_buf : block register, words leave from the MSW end
// Rev 1.0
// ==================================================================
module sd_block_shift_buf #(
   parameter int BLOCK_BITS = 4096,
   parameter int WORD_W     = 32
) (
   input  logic                  clk,
   input  logic                  load,
   input  logic                  shift,
   input  logic [BLOCK_BITS-1:0] load_data,
   output logic [WORD_W-1:0]     top_word
);

   logic [BLOCK_BITS-1:0] r_data;

   // Contents are don't-care until loaded, so no reset is needed
   always_ff @(posedge clk) begin
      if (load) begin
         r_data <= load_data;
      end else if (shift) begin
         r_data <= r_data << WORD_W;
      end
   end

   assign top_word = r_data[BLOCK_BITS-1 -: WORD_W];

endmodule
`default_nettype wire

// File: rtl/sd_block_loader.sv
`default_nettype none
// ==================================================================
// sd_block_loader : reads N SD blocks and streams them as words
// Rev 1.0
// ==================================================================
module sd_block_loader
   import sd_loader_pkg::*;
#(
   parameter int BLOCK_BITS = DEF_BLOCK_BITS,
   parameter int WORD_W     = DEF_WORD_W,
   parameter int CNT_W      = 16,
   parameter int TIMEOUT    = 50_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      start_block,
   input  logic [CNT_W-1:0] block_count,
   input  logic [31:0]      dest_base,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [1:0]       err_code,
   sd_block_loader_if.master bus
);

   localparam int N_WORDS = BLOCK_BITS / WORD_W;
   localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_WORDS - 1);
   localparam logic [31:0]      C_TO_LAST  = 32'(TIMEOUT - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [31:0]      r_tcnt;
   logic [31:0]      r_cur_block;
   logic [31:0]      r_addr;
   logic [CNT_W-1:0] r_blocks_left;
   logic [IDX_W-1:0] r_word_idx;
   logic             r_err;
   logic [1:0]       r_code;

   logic             w_sd_re;
   logic             w_m_valid;
   logic             w_accept;
   logic             w_to_hit;
   logic             w_last_word;
   logic             w_final_block;
   logic             w_buf_load;
   logic [WORD_W-1:0] w_top_word;

   assign w_accept      = w_m_valid & bus.m_ready;
   assign w_to_hit      = (r_tcnt == C_TO_LAST);
   assign w_last_word   = (r_word_idx == C_LAST_IDX);
   assign w_final_block = (r_blocks_left == CNT_W'(1));
   assign w_buf_load    = (r_state == S_REQ) & bus.sd_read_ok & ~bus.sd_read_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = (block_count == '0) ? S_DONE : S_WAIT_INIT;
            end
         end
         S_WAIT_INIT: begin
            if (bus.sd_init_ok) begin
               w_state_next = S_REQ;
            end else if (w_to_hit) begin
               w_state_next = S_DONE;
            end
         end
         S_REQ: begin
            if (bus.sd_read_err) begin
               w_state_next = S_DONE;
            end else if (bus.sd_read_ok) begin
               w_state_next = S_REL;
            end else if (w_to_hit) begin
               w_state_next = S_DONE;
            end
         end
         S_REL: begin
            if (!bus.sd_read_ok && !bus.sd_read_err) begin
               w_state_next = S_STREAM;
            end
         end
         S_STREAM: begin
            if (w_accept && w_last_word) begin
               w_state_next = w_final_block ? S_DONE : S_REQ;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state != S_IDLE) && (r_state != S_DONE);
      done      = (r_state == S_DONE);
      w_sd_re   = (r_state == S_REQ);
      w_m_valid = (r_state == S_STREAM);
   end

   // Timeout counter restarts on every state change and saturates at its compare value
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tcnt        <= '0;
         r_cur_block   <= '0;
         r_addr        <= '0;
         r_blocks_left <= '0;
         r_word_idx    <= '0;
         r_err         <= 1'b0;
         r_code        <= ERR_NONE;
      end else begin
         if (w_state_next != r_state) begin
            r_tcnt <= '0;
         end else if (!w_to_hit) begin
            r_tcnt <= r_tcnt + 32'd1;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_err         <= 1'b0;
                  r_code        <= ERR_NONE;
                  r_cur_block   <= start_block;
                  r_blocks_left <= block_count;
                  r_addr        <= dest_base;
                  r_word_idx    <= '0;
               end
            end
            S_WAIT_INIT: begin
               if (!bus.sd_init_ok && w_to_hit) begin
                  r_err  <= 1'b1;
                  r_code <= ERR_INIT_TO;
               end
            end
            S_REQ: begin
               if (bus.sd_read_err) begin
                  r_err  <= 1'b1;
                  r_code <= ERR_READ;
               end else if (!bus.sd_read_ok && w_to_hit) begin
                  r_err  <= 1'b1;
                  r_code <= ERR_READ_TO;
               end
            end
            S_STREAM: begin
               if (w_accept) begin
                  r_addr     <= r_addr + 32'd4;
                  r_word_idx <= w_last_word ? '0 : r_word_idx + IDX_W'(1);
                  if (w_last_word && !w_final_block) begin
                     r_cur_block   <= r_cur_block + 32'd1;
                     r_blocks_left <= r_blocks_left - CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   sd_block_shift_buf #(
      .BLOCK_BITS (BLOCK_BITS),
      .WORD_W     (WORD_W)
   ) u_buf (
      .clk       (clk),
      .load      (w_buf_load),
      .shift     (w_accept),
      .load_data (bus.sd_rdata),
      .top_word  (w_top_word)
   );

   assign error       = r_err;
   assign err_code    = r_code;
   assign bus.sd_addr = r_cur_block;
   assign bus.sd_re   = w_sd_re;
   assign bus.m_valid = w_m_valid;
   assign bus.m_data  = w_top_word;
   assign bus.m_addr  = r_addr;
   assign bus.m_last  = w_m_valid & w_last_word & w_final_block;

endmodule
`default_nettype wire

// File: tb/tb_sd_block_loader.sv
`default_nettype none
// ==================================================================
// tb_sd_block_loader : randomized scoreboard bench for sd_block_loader
// Rev 1.0
// ==================================================================
module tb_sd_block_loader;
   import sd_loader_pkg::*;

   localparam int BB = 4096;
   localparam int WW = 32;
   localparam int CW = 16;
   localparam int TO = 100;
   localparam int NW = BB / WW;

   typedef struct {
      logic [31:0] data;
      logic [31:0] addr;
      logic        last;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   start_block = '0;
   logic [CW-1:0] block_count = '0;
   logic [31:0]   dest_base = '0;
   logic          busy;
   logic          done;
   logic          error;
   logic [1:0]    err_code;

   sd_block_loader_if #(.BLOCK_BITS(BB), .WORD_W(WW)) bus ();

   sd_block_loader #(
      .BLOCK_BITS (BB),
      .WORD_W     (WW),
      .CNT_W      (CW),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .start_block (start_block),
      .block_count (block_count),
      .dest_base   (dest_base),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .err_code    (err_code),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   int unsigned cyc = 0;
   int unsigned start_cyc = 0;
   int unsigned done_cyc = 0;
   int          beats_seen = 0;
   int          dones_seen = 0;
   int          ready_pct = 100;
   int          err_req = -1;
   int          hang_req = -1;
   int          req_idx = 0;
   bit          inc_mode = 1'b0;
   logic [31:0] salt = '0;

   beat_t       exp_beats[$];
   logic [1:0]  exp_done[$];
   logic [31:0] exp_sd[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name, input string info);
      tests++;
      fails++;
      $display("FAIL %s: %s (cycle %0d)", name, info, cyc);
   endtask

   // Data an SD block carries: either a running count or a hash of address and word
   function automatic logic [31:0] gen_word(input logic [31:0] blk, input int seq, input int w);
      if (inc_mode) return 32'(seq * NW + w);
      return (blk * 32'h9E3779B1) ^ (32'(w) * 32'h85EBCA6B) ^ salt;
   endfunction

   initial begin
      bus.m_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.m_ready = ($urandom_range(0, 99) < ready_pct);
      end
   end

   // SD controller model: four-phase handshake with random latency
   initial begin
      int lat;
      int guard;
      bus.sd_read_ok  = 1'b0;
      bus.sd_read_err = 1'b0;
      bus.sd_init_ok  = 1'b1;
      bus.sd_rdata    = '0;
      forever begin
         @(posedge clk); #1;
         if (!reset && bus.sd_re && !bus.sd_read_ok && !bus.sd_read_err) begin
            lat = $urandom_range(0, 3);
            repeat (lat) begin @(posedge clk); #1; end
            if (exp_sd.size() == 0) fail_now("sd_unexpected_req", $sformatf("addr %0h", bus.sd_addr));
            else check("sd_addr", bus.sd_addr, exp_sd.pop_front());
            if (req_idx == err_req) begin
               bus.sd_read_err = 1'b1;
            end else if (req_idx != hang_req) begin
               for (int w = 0; w < NW; w++) bus.sd_rdata[BB-1-WW*w -: WW] = gen_word(bus.sd_addr, req_idx, w);
               bus.sd_read_ok = 1'b1;
            end
            req_idx++;
            guard = 0;
            while (bus.sd_re && guard < 1000) begin @(posedge clk); #1; guard++; end
            if (guard >= 1000) fail_now("sd_re_release", "sd_re never dropped");
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bus.sd_read_ok  = 1'b0;
            bus.sd_read_err = 1'b0;
         end
      end
   end

   // Output monitor: pops the scoreboard on every accepted beat and done pulse
   initial begin
      bit         stalled;
      beat_t      held;
      beat_t      e;
      logic [1:0] c;
      stalled = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               check("stall_valid", bus.m_valid, 1'b1);
               check("stall_data", bus.m_data, held.data);
               check("stall_addr", bus.m_addr, held.addr);
               check("stall_last", bus.m_last, held.last);
            end
            if (bus.m_valid && bus.m_ready) begin
               beats_seen++;
               stalled = 1'b0;
               if (exp_beats.size() == 0) begin
                  fail_now("beat_unexpected", $sformatf("data %0h addr %0h", bus.m_data, bus.m_addr));
               end else begin
                  e = exp_beats.pop_front();
                  check("beat_data", bus.m_data, e.data);
                  check("beat_addr", bus.m_addr, e.addr);
                  check("beat_last", bus.m_last, e.last);
               end
            end else if (bus.m_valid) begin
               stalled   = 1'b1;
               held.data = bus.m_data;
               held.addr = bus.m_addr;
               held.last = bus.m_last;
            end else begin
               stalled = 1'b0;
            end
            if (done) begin
               dones_seen++;
               done_cyc = cyc;
               if (exp_done.size() == 0) begin
                  fail_now("done_unexpected", $sformatf("err_code %0d", err_code));
               end else begin
                  c = exp_done.pop_front();
                  check("err_code", err_code, c);
                  check("error", error, c != ERR_NONE);
                  check("busy_at_done", busy, 1'b0);
               end
            end
         end
      end
   end

   // Reference: which blocks get read, which words stream out, and how the run ends
   task automatic issue_op(input logic [31:0] sb, input int cnt, input logic [31:0] db,
                           input int eb, input int hb);
      int         stop;
      int         nreq;
      logic [1:0] code;
      beat_t      b;
      stop = cnt;
      if (eb >= 0 && eb < stop) stop = eb;
      if (hb >= 0 && hb < stop) stop = hb;
      nreq = (stop < cnt) ? stop + 1 : cnt;
      code = ERR_NONE;
      if (stop < cnt) code = (stop == eb) ? ERR_READ : ERR_READ_TO;
      if (!bus.sd_init_ok && cnt != 0) begin
         stop = 0;
         nreq = 0;
         code = ERR_INIT_TO;
      end
      err_req  = eb;
      hang_req = hb;
      req_idx  = 0;
      for (int i = 0; i < nreq; i++) exp_sd.push_back(sb + 32'(i));
      for (int k = 0; k < stop; k++) begin
         for (int w = 0; w < NW; w++) begin
            b.data = gen_word(sb + 32'(k), k, w);
            b.addr = db + 32'(4 * (k * NW + w));
            b.last = (k == cnt - 1) && (w == NW - 1);
            exp_beats.push_back(b);
         end
      end
      exp_done.push_back(code);
      start_block = sb;
      block_count = CW'(cnt);
      dest_base   = db;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input int budget, input int exp_lat);
      int g;
      g = 0;
      while (exp_done.size() != 0 && g < budget) begin @(posedge clk); g++; end
      if (exp_done.size() != 0) begin
         fail_now("done_timeout", $sformatf("no done within %0d cycles", budget));
         exp_done.delete();
      end else if (exp_lat >= 0) begin
         check("done_latency", done_cyc - start_cyc, exp_lat);
      end
      repeat (4) @(posedge clk);
      #1;
      check("beats_missing", exp_beats.size(), 0);
      check("sd_reqs_missing", exp_sd.size(), 0);
      check("sd_re_idle", bus.sd_re, 1'b0);
      check("busy_idle", busy, 1'b0);
      exp_beats.delete();
      exp_sd.delete();
   endtask

   initial begin
      int g;
      int b0;
      int d0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_err_code", err_code, 2'b00);
      check("rst_m_valid", bus.m_valid, 1'b0);
      check("rst_m_last", bus.m_last, 1'b0);
      check("rst_m_addr", bus.m_addr, 32'h0);
      check("rst_sd_re", bus.sd_re, 1'b0);
      check("rst_sd_addr", bus.sd_addr, 32'h0);
      reset = 1'b0;

      // single block, counting data
      inc_mode = 1'b1;
      ready_pct = 100;
      issue_op(32'h10, 1, 32'h1000, -1, -1);
      wait_done(3000, -1);

      // block address wraps, random data
      inc_mode = 1'b0;
      salt = $urandom;
      issue_op(32'hFFFF_FFFF, 3, $urandom, -1, -1);
      wait_done(5000, -1);

      // heavy back-pressure
      ready_pct = 30;
      salt = $urandom;
      issue_op($urandom, 2, $urandom, -1, -1);
      wait_done(8000, -1);

      // read error on the second of four blocks
      ready_pct = 70;
      salt = $urandom;
      issue_op($urandom, 4, $urandom, 1, -1);
      wait_done(8000, -1);

      // init timeout, with a second start while busy
      ready_pct = 100;
      bus.sd_init_ok = 1'b0;
      issue_op($urandom, 2, $urandom, -1, -1);
      repeat (30) @(posedge clk);
      #1;
      block_count = CW'(5);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1000, TO);
      bus.sd_init_ok = 1'b1;

      // SD never answers the first request
      issue_op($urandom, 2, $urandom, -1, 0);
      wait_done(1000, -1);

      // random runs, one with the destination address wrapping
      for (int i = 0; i < 3; i++) begin
         ready_pct = $urandom_range(40, 100);
         salt = $urandom;
         issue_op($urandom, $urandom_range(1, 2), (i == 0) ? 32'hFFFF_FF00 : $urandom, -1, -1);
         wait_done(6000, -1);
      end

      // reset in the middle of streaming, then a zero-length start
      ready_pct = 100;
      salt = $urandom;
      b0 = beats_seen;
      issue_op($urandom, 2, $urandom, -1, -1);
      g = 0;
      while (beats_seen - b0 < 50 && g < 2000) begin @(posedge clk); g++; end
      if (beats_seen - b0 < 50) fail_now("reach_beat_50", "stream never reached beat 50");
      #1;
      reset = 1'b1;
      exp_beats.delete();
      exp_done.delete();
      exp_sd.delete();
      @(posedge clk); #1;
      check("mid_rst_m_valid", bus.m_valid, 1'b0);
      check("mid_rst_sd_re", bus.sd_re, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      reset = 1'b0;
      d0 = dones_seen;
      repeat (10) @(posedge clk);
      #1;
      check("no_done_after_reset", dones_seen - d0, 0);
      issue_op($urandom, 0, $urandom, -1, -1);
      wait_done(50, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
